mips_cpu_bus: RTL and testbench
===============================

// Module: mips_cpu_bus
// PURPOSE
//  Multicycle MIPS-I subset CPU (little-endian) with one shared instruction/data memory bus.
//  The bus uses read/write strobes, a waitrequest stall and byte enables.
//  Boots from 0xBFC00000 and halts when execution jumps to address 0.
//  register_v0 exposes $2 for test observation.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  first fetch address after reset
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset        in   1   asynchronous, active-high
//  active       out  1   1 while running; 0 once halted
//  register_v0  out  32  live value of GPR $2
//  address      out  32  byte address, always word aligned (bits[1:0]=0)
//  write        out  1   write strobe
//  read         out  1   read strobe
//  waitrequest  in   1   memory stall; a strobed transfer completes on a clk edge with waitrequest=0
//  writedata    out  32  store data, placed on its byte lane
//  byteenable   out  4   lane enables; bit i covers data[8i+7:8i]
//  readdata     in   32  read data, valid the cycle after the accepted read
// BEHAVIOUR
//  Reset (async):
//  - PC=RESET_VECTOR; all 32 GPRs=0; register_v0=0.
//  - active=1; read=0, write=0; address=0; writedata=0; byteenable=0.
//  - State=FETCH.
//  Never assert read and write together.
//  FSM: FETCH -> EXEC -> [MEM] -> [WB] -> FETCH; HALT is terminal.
//  FETCH:
//  - If PC==0: go to HALT.
//  - Else drive read=1, address=PC, byteenable=4'b1111, and hold all of these while waitrequest=1.
//  - Latch the instruction from readdata one cycle after acceptance.
//  EXEC:
//  - Decode; read rs/rt; perform ALU op, branch compare and address calculation.
//  - Non-memory instructions write back here and return to FETCH.
//  MEM:
//  - Loads: drive read=1, address=aligned EA.
//  - Stores: drive write=1 with enables and lane-shifted data.
//  - Hold all bus outputs while waitrequest=1.
//  WB: load result written (sign/zero extended) one cycle after the read is accepted.
//  HALT: active=0, read=0, write=0; remain until reset.
//  Instruction set:
//  - ALU: addu subu and or xor nor slt sltu sll srl sra sllv srlv srav.
//  - Immediates: addiu andi ori xori slti sltiu lui.
//  - Loads: lw lh lhu lb lbu. Stores: sw sh sb.
//  - Branches/jumps: beq bne bgtz blez bltz bgez j jal jr jalr.
//  - add/addi behave as addu/addiu (no overflow trap).
//  - Any other opcode executes as a NOP.
//  Arithmetic rules:
//  - slt/slti are signed 32-bit compares; sltu/sltiu unsigned.
//  - Logical immediates are zero-extended; all others sign-extended.
//  - Shift amounts are 5 bits.
//  Register $0: reads return 0; writes are discarded.
//  Branch delay slot:
//  - The instruction at PC+4 after any branch/jump always executes.
//  - PC then becomes the taken target, or PC+8 if not taken.
//  - Branch target = PC+4 + (sext(imm)<<2).
//  - j/jal target = {PC+4[31:28], idx, 2'b00}.
//  - jal/jalr link = PC+8; jal links into $31.
//  - A jump to 0 halts only after its delay slot has completed.
//  - A branch/jump placed in a delay slot: its behaviour is unspecified; the bench must not test it.
//  No load delay slot: the result is usable by the next instruction.
//  Sub-word accesses:
//  - EA[1:0] selects the lane; sh uses 4'b0011 or 4'b1100, sb a single-bit enable.
//  - Misaligned lw/sw/lh/sh: treat EA[1:0] (or EA[0]) as 0.
// TESTING
//  - slt_2 program at 0xBFC00000:
//      3C08BFC0 (lui $t0,0xBFC0), 8D09002C (lw $t1,0x2C($t0)), 8D0A0030 (lw $t2,0x30($t0)),
//      00000008 (jr $0), 0149102A (slt $v0,$t2,$t1)
//    data words at +0x2C and +0x30 both = 2, waitrequest=0
//    -> active=0 within 5000 cycles, register_v0=0.
//  - Same program with data word at +0x30 = 0xFFFFFFFF and at +0x2C = 1 -> register_v0=1;
//    sltu variant -> register_v0=0.
//  - active=1 one cycle after reset is released.
//  - Random waitrequest stalls on every transfer: address/read/write stay stable, final register_v0 unchanged.
//  - sw then lw back: write=1, byteenable=4'b1111, data read back matches.
//  - sb to EA[1:0]=2: byteenable=4'b0100; lbu of 0x80 -> 0x00000080; lb -> 0xFFFFFF80.
//  - beq taken with addiu $v0 in its delay slot: delay-slot result is committed and the fall-through instruction is skipped.
//  - Assert reset mid-execution: bus goes idle immediately; fetch restarts at 0xBFC00000 with $v0=0.

Source files
------------

// File: rtl/mips_cpu_bus.sv
// Multicycle little-endian MIPS-I subset CPU sharing one memory bus for fetch and data.
// Bus strobes are registered; a strobed transfer completes on a clock edge with waitrequest low.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [2:0] StFetch = 3'd0;
  localparam logic [2:0] StExec  = 3'd1;
  localparam logic [2:0] StMem   = 3'd2;
  localparam logic [2:0] StWb    = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc, npc, ir;
  logic [1:0]  ea_lo;
  logic [31:0] regs [32];

  logic [31:0] instr, rs_val, rt_val, simm, zimm, pc4, br_target, ea_calc;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  // The instruction is only on readdata during the exec cycle; later states use the latched copy.
  assign instr     = (state == StExec) ? readdata : ir;
  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  assign rs_val    = regs[rs];
  assign rt_val    = regs[rt];
  assign simm      = {{16{imm[15]}}, imm};
  assign zimm      = {16'h0000, imm};
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {simm[29:0], 2'b00};
  assign ea_calc   = rs_val + simm;

  logic        ex_we, taken, is_load, is_store;
  logic [4:0]  ex_wa;
  logic [31:0] ex_wd, target, st_data;
  logic [3:0]  st_be;

  always_comb begin
    ex_we    = 1'b0;
    ex_wa    = rt;
    ex_wd    = '0;
    taken    = 1'b0;
    target   = br_target;
    is_load  = 1'b0;
    is_store = 1'b0;
    st_be    = 4'b1111;
    st_data  = rt_val;
    case (op)
      6'h00: begin
        ex_wa = rd;
        ex_we = 1'b1;
        case (funct)
          6'h00: ex_wd = rt_val << shamt;
          6'h02: ex_wd = rt_val >> shamt;
          6'h03: ex_wd = $signed(rt_val) >>> shamt;
          6'h04: ex_wd = rt_val << rs_val[4:0];
          6'h06: ex_wd = rt_val >> rs_val[4:0];
          6'h07: ex_wd = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin ex_we = 1'b0; taken = 1'b1; target = rs_val; end
          6'h09: begin taken = 1'b1; target = rs_val; ex_wd = pc + 32'd8; end
          6'h20, 6'h21: ex_wd = rs_val + rt_val;
          6'h22, 6'h23: ex_wd = rs_val - rt_val;
          6'h24: ex_wd = rs_val & rt_val;
          6'h25: ex_wd = rs_val | rt_val;
          6'h26: ex_wd = rs_val ^ rt_val;
          6'h27: ex_wd = ~(rs_val | rt_val);
          6'h2A: ex_wd = {31'b0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: ex_wd = {31'b0, rs_val < rt_val};
          default: ex_we = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) taken = rs_val[31];
        else if (rt == 5'd1) taken = ~rs_val[31];
      end
      6'h02: begin taken = 1'b1; target = {pc4[31:28], instr[25:0], 2'b00}; end
      6'h03: begin
        taken  = 1'b1;
        target = {pc4[31:28], instr[25:0], 2'b00};
        ex_we  = 1'b1;
        ex_wa  = 5'd31;
        ex_wd  = pc + 32'd8;
      end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[31] | (rs_val == '0);
      6'h07: taken = ~rs_val[31] & (rs_val != '0);
      6'h08, 6'h09: begin ex_we = 1'b1; ex_wd = rs_val + simm; end
      6'h0A: begin ex_we = 1'b1; ex_wd = {31'b0, $signed(rs_val) < $signed(simm)}; end
      6'h0B: begin ex_we = 1'b1; ex_wd = {31'b0, rs_val < simm}; end
      6'h0C: begin ex_we = 1'b1; ex_wd = rs_val & zimm; end
      6'h0D: begin ex_we = 1'b1; ex_wd = rs_val | zimm; end
      6'h0E: begin ex_we = 1'b1; ex_wd = rs_val ^ zimm; end
      6'h0F: begin ex_we = 1'b1; ex_wd = {imm, 16'h0000}; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load = 1'b1;
      6'h28: begin
        is_store = 1'b1;
        st_be    = 4'b0001 << ea_calc[1:0];
        st_data  = rt_val << {ea_calc[1:0], 3'b000};
      end
      6'h29: begin
        is_store = 1'b1;
        st_be    = ea_calc[1] ? 4'b1100 : 4'b0011;
        st_data  = ea_calc[1] ? {rt_val[15:0], 16'h0000} : {16'h0000, rt_val[15:0]};
      end
      6'h2B: is_store = 1'b1;
      default: ;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = readdata[{ea_lo, 3'b000} +: 8];
    ld_half = ea_lo[1] ? readdata[31:16] : readdata[15:0];
    case (ir[31:26])
      6'h20:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   ld_val = {24'h000000, ld_byte};
      6'h21:   ld_val = {{16{ld_half[15]}}, ld_half};
      6'h25:   ld_val = {16'h0000, ld_half};
      default: ld_val = readdata;
    endcase
  end

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = ex_wa;
    rf_wd = ex_wd;
    if (state == StExec) begin
      rf_we = ex_we;
    end else if (state == StWb) begin
      rf_we = 1'b1;
      rf_wa = ir[20:16];
      rf_wd = ld_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      regs[rf_wa] <= rf_wd;
    end
  end

  assign register_v0 = regs[2];
  assign active      = (state != StHalt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StFetch;
      pc         <= RESET_VECTOR;
      npc        <= RESET_VECTOR + 32'd4;
      ir         <= '0;
      ea_lo      <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      case (state)
        StFetch: begin
          if (!read) begin
            if (pc == '0) begin
              state <= StHalt;
            end else begin
              read       <= 1'b1;
              address    <= pc;
              byteenable <= 4'b1111;
            end
          end else if (!waitrequest) begin
            read  <= 1'b0;
            state <= StExec;
          end
        end
        StExec: begin
          ir    <= readdata;
          ea_lo <= ea_calc[1:0];
          // Delay slot: the next sequential instruction always runs before the target.
          pc    <= npc;
          npc   <= taken ? target : npc + 32'd4;
          if (is_load) begin
            read       <= 1'b1;
            address    <= {ea_calc[31:2], 2'b00};
            byteenable <= 4'b1111;
            state      <= StMem;
          end else if (is_store) begin
            write      <= 1'b1;
            address    <= {ea_calc[31:2], 2'b00};
            byteenable <= st_be;
            writedata  <= st_data;
            state      <= StMem;
          end else begin
            state <= StFetch;
          end
        end
        StMem: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= read ? StWb : StFetch;
          end
        end
        StWb:    state <= StFetch;
        StHalt:  state <= StHalt;
        default: state <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Self-checking bench for mips_cpu_bus: small programs run from a memory model with optional
// random waitrequest stalls; final $v0 and observed stores are scored against queued expectations.
module tb_mips_cpu_bus;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, read, write;
  logic        waitrequest = 1'b0;
  logic [31:0] register_v0, address, writedata;
  logic [31:0] readdata = '0;
  logic [3:0]  byteenable;

  mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] exp_v0 [$];
  wr_t         exp_wr [$];
  wr_t         obs_wr [$];
  wr_t         obs_tmp;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_err = 0;
  int hold_cnt = 0;
  int rw_both  = 0;
  bit stall_en = 1'b0;
  bit pend     = 1'b0;
  logic        p_rd, p_wr;
  logic [31:0] p_ad, p_wd;
  logic [3:0]  p_be;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (wmem.exists(wa)) return wmem[wa];
    if (imem.exists(wa)) return imem[wa];
    return '0;
  endfunction

  // Memory: read data appears the cycle after acceptance; stores merge by byte lane.
  always @(posedge clk) begin
    if (reset) begin
      wmem.delete();
    end else if (read && !waitrequest) begin
      readdata <= mem_word(address >> 2);
    end else if (write && !waitrequest) begin
      wmem[address >> 2] = (mem_word(address >> 2) & ~lane_mask(byteenable)) |
                           (writedata & lane_mask(byteenable));
    end
  end

  // Stall generation, bus-hold monitoring and store capture, all away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      pend        = 1'b0;
      hold_err    = 0;
      hold_cnt    = 0;
      rw_both     = 0;
      waitrequest = 1'b0;
      obs_wr.delete();
    end else begin
      if (pend) begin
        hold_cnt++;
        if (read !== p_rd || write !== p_wr || address !== p_ad || byteenable !== p_be ||
            (write && writedata !== p_wd)) hold_err++;
      end
      if (read && write) rw_both++;
      waitrequest = stall_en && ($urandom_range(0, 1) == 1);
      if (write && !waitrequest) begin
        obs_tmp.a  = address;
        obs_tmp.be = byteenable;
        obs_tmp.d  = writedata & lane_mask(byteenable);
        obs_wr.push_back(obs_tmp);
      end
      pend = (read || write) && waitrequest;
      p_rd = read;
      p_wr = write;
      p_ad = address;
      p_be = byteenable;
      p_wd = writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    imem[(RV >> 2) + 32'(idx)] = w;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 5000 && active; i++) @(negedge clk);
    check({tag, ":halt"}, {31'b0, active}, 32'd0);
  endtask

  task automatic check_stores(input string tag);
    check({tag, ":nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check({tag, ":wr_addr"}, obs_wr[i].a, exp_wr[i].a);
      check({tag, ":wr_be"}, {28'b0, obs_wr[i].be}, {28'b0, exp_wr[i].be});
      check({tag, ":wr_data"}, obs_wr[i].d, exp_wr[i].d);
    end
    exp_wr.delete();
  endtask

  task automatic run_prog(input string tag, input bit stall);
    stall_en = stall;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({tag, ":rst_active"}, {31'b0, active}, 32'd1);
    check({tag, ":rst_strobes"}, {30'b0, read, write}, 32'd0);
    check({tag, ":rst_addr"}, address, 32'd0);
    check({tag, ":rst_be_wd"}, {28'b0, byteenable} | writedata, 32'd0);
    check({tag, ":rst_v0"}, register_v0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check({tag, ":active_after_rst"}, {31'b0, active}, 32'd1);
    wait_halt(tag);
    check({tag, ":v0"}, register_v0, exp_v0.pop_front());
    check_stores(tag);
    check({tag, ":hold"}, 32'(hold_err), 32'd0);
    check({tag, ":rw_excl"}, 32'(rw_both), 32'd0);
    if (stall) check({tag, ":stalls_seen"}, {31'b0, hold_cnt > 0}, 32'd1);
  endtask

  task automatic slt_prog(input logic [31:0] slt_word, input logic [31:0] d2c,
                          input logic [31:0] d30);
    imem.delete();
    put(0, 32'h3C08BFC0);
    put(1, 32'h8D09002C);
    put(2, 32'h8D0A0030);
    put(3, 32'h00000008);
    put(4, slt_word);
    put(11, d2c);
    put(12, d30);
  endtask

  task automatic sb_prog(input logic [31:0] load_word);
    imem.delete();
    put(0, 32'h3C08BFC0);   // lui   $t0,0xBFC0
    put(1, 32'h24090080);   // addiu $t1,$0,0x80
    put(2, 32'hA1090042);   // sb    $t1,0x42($t0)
    put(3, load_word);      // lbu/lb $v0,0x42($t0)
    put(4, 32'h00000008);   // jr    $0
    put(5, 32'h00000000);
    put(16, 32'h11223344);
  endtask

  task automatic beq_prog();
    imem.delete();
    put(0, 32'h10000002);   // beq   $0,$0,+2
    put(1, 32'h24020005);   // addiu $v0,$0,5 (delay slot)
    put(2, 32'h24420100);   // addiu $v0,$v0,0x100 (must be skipped)
    put(3, 32'h00000008);   // jr    $0
    put(4, 32'h24420001);   // addiu $v0,$v0,1 (delay slot)
  endtask

  wr_t ew;

  initial begin
    slt_prog(32'h0149102A, 32'd2, 32'd2);
    exp_v0.push_back(32'd0);
    run_prog("slt_eq", 1'b0);

    slt_prog(32'h0149102A, 32'd1, 32'hFFFFFFFF);
    exp_v0.push_back(32'd1);
    run_prog("slt_neg", 1'b0);

    slt_prog(32'h0149102B, 32'd1, 32'hFFFFFFFF);
    exp_v0.push_back(32'd0);
    run_prog("sltu", 1'b0);

    slt_prog(32'h0149102A, 32'd1, 32'hFFFFFFFF);
    exp_v0.push_back(32'd1);
    run_prog("slt_stall", 1'b1);

    imem.delete();
    put(0, 32'h3C08BFC0);   // lui   $t0,0xBFC0
    put(1, 32'h3C09DEAD);   // lui   $t1,0xDEAD
    put(2, 32'h3529BEEF);   // ori   $t1,$t1,0xBEEF
    put(3, 32'hAD090040);   // sw    $t1,0x40($t0)
    put(4, 32'h8D020040);   // lw    $v0,0x40($t0)
    put(5, 32'h00000008);   // jr    $0
    put(6, 32'h00000000);
    exp_v0.push_back(32'hDEADBEEF);
    ew.a = RV + 32'h40; ew.be = 4'b1111; ew.d = 32'hDEADBEEF;
    exp_wr.push_back(ew);
    run_prog("sw_lw", 1'b1);

    sb_prog(32'h91020042);
    exp_v0.push_back(32'h00000080);
    ew.a = RV + 32'h40; ew.be = 4'b0100; ew.d = 32'h00800000;
    exp_wr.push_back(ew);
    run_prog("sb_lbu", 1'b0);

    sb_prog(32'h81020042);
    exp_v0.push_back(32'hFFFFFF80);
    ew.a = RV + 32'h40; ew.be = 4'b0100; ew.d = 32'h00800000;
    exp_wr.push_back(ew);
    run_prog("sb_lb", 1'b1);

    beq_prog();
    exp_v0.push_back(32'd6);
    run_prog("beq", 1'b0);

    // Reset in the middle of a stalled run, then let the program run again to completion.
    beq_prog();
    exp_v0.push_back(32'd6);
    stall_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2000 && register_v0 == '0 && active; i++) @(negedge clk);
    check("mid:v0_set", register_v0, 32'd5);
    reset = 1'b1;
    #1;
    check("mid:strobes", {30'b0, read, write}, 32'd0);
    check("mid:addr", address, 32'd0);
    check("mid:v0", register_v0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid:active", {31'b0, active}, 32'd1);
    for (int i = 0; i < 50 && !read; i++) @(negedge clk);
    check("mid:refetch_rd", {31'b0, read}, 32'd1);
    check("mid:refetch_addr", address, RV);
    wait_halt("mid");
    check("mid:final_v0", register_v0, exp_v0.pop_front());
    check("mid:hold", 32'(hold_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
